// File: rtl/feed_dispatcher.sv
// Round-robin task dispatcher and result merger for a pool of solver lanes.
// Buffers one task, grants it to the next eligible lane, and merges lane results into one output register.
module feed_dispatcher #(
  parameter int unsigned LANES        = 4,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [143:0]          in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [143:0]          lane_data,
  output logic [LANES-1:0]      lane_valid,
  input  logic [LANES-1:0]      lane_ready,
  input  logic [40*LANES-1:0]   lane_result,
  input  logic [LANES-1:0]      lane_result_valid,
  output logic [LANES-1:0]      lane_result_ready,
  output logic [39:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int unsigned PW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [143:0]   tbuf_q, tbuf_d;
  logic           tbuf_valid_q, tbuf_valid_d;
  logic [PW-1:0]  dptr_q, dptr_d;
  logic [PW-1:0]  cptr_q, cptr_d;
  logic [3:0]     inflight_q [LANES];
  logic [3:0]     inflight_d [LANES];
  logic [39:0]    out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;

  logic [LANES-1:0] elig;
  logic [PW-1:0]    dgrant, cgrant;
  logic             dfound, cfound;
  logic             dispatch_fire, collect_fire, accept;
  logic             any_inflight;

  // Returns {found, index} of the first requester at or after ptr, wrapping.
  function automatic logic [PW:0] rr_pick(input logic [LANES-1:0] req,
                                          input logic [PW-1:0]    ptr);
    logic          found;
    logic [PW-1:0] idx;
    int unsigned   cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      cand = int'(ptr) + i;
      if (cand >= LANES) cand = cand - LANES;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = PW'(cand);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
    return (g == PW'(LANES - 1)) ? '0 : g + PW'(1);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      elig[i] = lane_ready[i] && (inflight_q[i] < 4'(MAX_INFLIGHT));
    end
  end

  always_comb begin
    {dfound, dgrant} = rr_pick(elig, dptr_q);
    {cfound, cgrant} = rr_pick(lane_result_valid, cptr_q);
  end

  // An eligible grant already implies lane_ready, so the fire needs no extra term.
  assign dispatch_fire     = tbuf_valid_q && dfound;
  assign collect_fire      = cfound && (!out_valid_q || out_ready);
  assign in_ready          = !tbuf_valid_q || dispatch_fire;
  assign accept            = in_valid && in_ready;
  assign lane_valid        = dispatch_fire ? (LANES'(1) << dgrant) : '0;
  assign lane_data         = tbuf_q;
  assign lane_result_ready = collect_fire ? (LANES'(1) << cgrant) : '0;
  assign out_data          = out_data_q;
  assign out_valid         = out_valid_q;

  always_comb begin
    any_inflight = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (inflight_q[i] != 4'd0) any_inflight = 1'b1;
    end
  end

  assign busy = tbuf_valid_q || any_inflight || out_valid_q;

  always_comb begin
    tbuf_d       = accept ? in_data : tbuf_q;
    tbuf_valid_d = accept ? 1'b1 : (dispatch_fire ? 1'b0 : tbuf_valid_q);
    dptr_d       = dispatch_fire ? next_ptr(dgrant) : dptr_q;
    cptr_d       = collect_fire ? next_ptr(cgrant) : cptr_q;
    out_data_d   = collect_fire ? lane_result[cgrant*40 +: 40] : out_data_q;
    out_valid_d  = collect_fire ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
  end

  // A result on an idle lane is still accepted; the counter saturates at zero.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      inflight_d[i] = inflight_q[i];
      if (dispatch_fire && (dgrant == PW'(i)) &&
          !(collect_fire && (cgrant == PW'(i)))) begin
        inflight_d[i] = inflight_q[i] + 4'd1;
      end else if (collect_fire && (cgrant == PW'(i)) &&
                   !(dispatch_fire && (dgrant == PW'(i)))) begin
        if (inflight_q[i] != 4'd0) inflight_d[i] = inflight_q[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tbuf_q       <= '0;
      tbuf_valid_q <= 1'b0;
      dptr_q       <= '0;
      cptr_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) inflight_q[i] <= '0;
    end else begin
      tbuf_q       <= tbuf_d;
      tbuf_valid_q <= tbuf_valid_d;
      dptr_q       <= dptr_d;
      cptr_q       <= cptr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      for (int unsigned i = 0; i < LANES; i++) inflight_q[i] <= inflight_d[i];
    end
  end

endmodule

// File: tb/tb_feed_dispatcher.sv
// Directed bench for feed_dispatcher: reset, round-robin dispatch, saturation,
// lane skipping, result merge order and output backpressure.
module tb_feed_dispatcher;

  localparam int unsigned LANES = 4;

  logic               clock = 1'b0;
  logic               reset_n;
  logic [143:0]       in_data;
  logic               in_valid;
  logic               in_ready;
  logic [143:0]       lane_data;
  logic [LANES-1:0]   lane_valid;
  logic [LANES-1:0]   lane_ready;
  logic [40*LANES-1:0] lane_result;
  logic [LANES-1:0]   lane_result_valid;
  logic [LANES-1:0]   lane_result_ready;
  logic [39:0]        out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  int n_cmp  = 0;
  int n_fail = 0;

  feed_dispatcher #(.LANES(LANES), .MAX_INFLIGHT(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .lane_data(lane_data), .lane_valid(lane_valid), .lane_ready(lane_ready),
    .lane_result(lane_result), .lane_result_valid(lane_result_valid),
    .lane_result_ready(lane_result_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [143:0] mk_task(input logic [15:0] tid);
    return {48'h1234_5678_9ABC, tid, 48'hFEDC_BA98_7654, tid, tid};
  endfunction

  function automatic logic [39:0] mk_res(input int unsigned lane);
    return {8'(8'hA0 + lane), 16'(16'h0100 + lane), 16'(16'h0010 * lane)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid          = 1'b0;
    in_data           = '0;
    lane_ready        = '1;
    lane_result       = '0;
    lane_result_valid = '0;
    out_ready         = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (lane_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_lane_valid got=%b exp=0000", lane_valid); end
    n_cmp++; if (lane_result_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_lrr got=%b exp=0000", lane_result_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (out_data !== 40'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
  endtask

  // Tasks 0..7 fill every lane to MAX_INFLIGHT=2; task 8 waits until lane 0 returns a result.
  task automatic test_rr_saturation();
    logic [3:0] exp_lv;
    do_reset();
    for (int k = 0; k <= 9; k++) begin
      if (k <= 8) begin
        in_valid = 1'b1;
        in_data  = mk_task(16'(k));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k == 0) exp_lv = 4'b0000;
      else if (k <= 8) exp_lv = 4'b0001 << ((k - 1) % 4);
      else exp_lv = 4'b0000;
      n_cmp++; if (lane_valid !== exp_lv) begin n_fail++; $display("FAIL rr_lane_valid[%0d] got=%b exp=%b", k, lane_valid, exp_lv); end
      if (k >= 1 && k <= 8) begin
        n_cmp++; if (lane_data !== mk_task(16'(k - 1))) begin n_fail++; $display("FAIL rr_lane_data[%0d] got=%h exp=%h", k, lane_data, mk_task(16'(k - 1))); end
      end
      n_cmp++; if (in_ready !== (k <= 8)) begin n_fail++; $display("FAIL rr_in_ready[%0d] got=%b exp=%b", k, in_ready, (k <= 8)); end
      tick();
    end
    lane_result_valid = 4'b0001;
    lane_result[39:0] = mk_res(0);
    #1;
    n_cmp++; if (lane_result_ready !== 4'b0001) begin n_fail++; $display("FAIL sat_lrr got=%b exp=0001", lane_result_ready); end
    n_cmp++; if (lane_valid !== 4'b0000) begin n_fail++; $display("FAIL sat_held_lane_valid got=%b exp=0000", lane_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL sat_held_in_ready got=%b exp=0", in_ready); end
    tick();
    lane_result_valid = 4'b0000;
    #1;
    n_cmp++; if (lane_valid !== 4'b0001) begin n_fail++; $display("FAIL sat_release_lane_valid got=%b exp=0001", lane_valid); end
    n_cmp++; if (lane_data !== mk_task(16'd8)) begin n_fail++; $display("FAIL sat_release_data got=%h exp=%h", lane_data, mk_task(16'd8)); end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_out_valid got=%b exp=1", out_valid); end
    n_cmp++; if (out_data !== mk_res(0)) begin n_fail++; $display("FAIL sat_out_data got=%h exp=%h", out_data, mk_res(0)); end
    tick();
    #1;
    n_cmp++; if (lane_valid !== 4'b0000) begin n_fail++; $display("FAIL sat_after_lane_valid got=%b exp=0000", lane_valid); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_after_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sat_after_busy got=%b exp=1", busy); end
  endtask

  task automatic test_reset_midop();
    in_valid = 1'b1;
    in_data  = mk_task(16'hBEEF);
    tick();
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (lane_valid !== 4'b0000) begin n_fail++; $display("FAIL midrst_lane_valid got=%b exp=0000", lane_valid); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_skip_ineligible();
    do_reset();
    for (int k = 0; k <= 4; k++) begin
      in_valid   = (k <= 3);
      in_data    = mk_task(16'(16'h0200 + k));
      lane_ready = (k == 3) ? 4'b1011 : 4'b1111;
      #1;
      case (k)
        0: begin n_cmp++; if (lane_valid !== 4'b0000) begin n_fail++; $display("FAIL skip_lv0 got=%b exp=0000", lane_valid); end end
        1: begin n_cmp++; if (lane_valid !== 4'b0001) begin n_fail++; $display("FAIL skip_lv1 got=%b exp=0001", lane_valid); end end
        2: begin n_cmp++; if (lane_valid !== 4'b0010) begin n_fail++; $display("FAIL skip_lv2 got=%b exp=0010", lane_valid); end end
        3: begin n_cmp++; if (lane_valid !== 4'b1000) begin n_fail++; $display("FAIL skip_lv3 got=%b exp=1000", lane_valid); end end
        default: begin n_cmp++; if (lane_valid !== 4'b0001) begin n_fail++; $display("FAIL skip_wrap got=%b exp=0001", lane_valid); end end
      endcase
      tick();
    end
    lane_ready = 4'b1111;
  endtask

  task automatic test_merge();
    do_reset();
    for (int i = 0; i < 4; i++) lane_result[40*i +: 40] = mk_res(i);
    lane_result_valid = 4'b1111;
    for (int k = 0; k <= 4; k++) begin
      if (k == 4) lane_result_valid = 4'b0000;
      #1;
      if (k < 4) begin
        n_cmp++; if (lane_result_ready !== (4'b0001 << k)) begin n_fail++; $display("FAIL merge_lrr[%0d] got=%b exp=%b", k, lane_result_ready, 4'b0001 << k); end
      end
      if (k > 0) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL merge_out_valid[%0d] got=%b exp=1", k, out_valid); end
        n_cmp++; if (out_data !== mk_res(k - 1)) begin n_fail++; $display("FAIL merge_out_data[%0d] got=%h exp=%h", k, out_data, mk_res(k - 1)); end
      end
      tick();
    end
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL merge_drain got=%b exp=0", out_valid); end
  endtask

  // Continues from test_merge with cptr back at 0.
  task automatic test_backpressure();
    lane_result_valid = 4'b0011;
    out_ready         = 1'b0;
    #1;
    n_cmp++; if (lane_result_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_first_lrr got=%b exp=0001", lane_result_ready); end
    tick();
    lane_result_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (out_data !== mk_res(0) || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d] got=%h/%b exp=%h/1", k, out_data, out_valid, mk_res(0)); end
      n_cmp++; if (lane_result_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_lrr[%0d] got=%b exp=0000", k, lane_result_ready); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (lane_result_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_lrr got=%b exp=0010", lane_result_ready); end
    tick();
    lane_result_valid = 4'b0000;
    #1;
    n_cmp++; if (out_data !== mk_res(1) || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next got=%h/%b exp=%h/1", out_data, out_valid, mk_res(1)); end
    tick();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_valid got=%b exp=0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_drain_busy got=%b exp=0", busy); end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_rr_saturation();
    test_reset_midop();
    test_skip_ineligible();
    test_merge();
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
